muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
Multi-cycle multiply/divide unit that owns the architectural HI/LO registers for the single-issue MIPS pipeline.
- Accepts MULT/MULTU/DIV/DIVU from the EXE stage and runs a 1-bit-per-cycle iterative engine.
- Serves MFHI/MFLO/MTHI/MTLO.
- Produces the pipeline FREEZE when EXE hits a HI/LO structural hazard.

Parameters:
DATA_W, 32, operand width; HI and LO are each DATA_W bits.
HILO_RST, 0, reset value loaded into HI and LO.

Ports:
CLK  input  1  clock, rising edge.
RESET  input  1  asynchronous, active-low reset.
start  input  1  EXE issues a multiply/divide this cycle.
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
opa  input  DATA_W  rs operand (multiplicand / dividend).
opb  input  DATA_W  rt operand (multiplier / divisor).
mfhi_req  input  1  EXE instruction reads HI this cycle.
mflo_req  input  1  EXE instruction reads LO this cycle.
mthi_we  input  1  write wdata into HI.
mtlo_we  input  1  write wdata into LO.
wdata  input  DATA_W  MTHI/MTLO data.
hi  output  DATA_W  registered HI.
lo  output  DATA_W  registered LO.
busy  output  1  operation in flight.
done  output  1  one-cycle pulse when the HI/LO result is committed.
freeze  output  1  stall request to the IF/ID/EXE pipeline registers.
div_zero  output  1  last DIV/DIVU had divisor 0; sticky until the next accepted start.

Behaviour:
- Reset: RESET low asynchronously forces state IDLE and clears the iteration count. Outputs go to hi=lo=HILO_RST, busy=0, done=0, freeze=0, div_zero=0. This also applies mid-operation; the in-flight result is discarded.
- States: IDLE, CALC, FIX.
- IDLE, start=1 at edge E0:
  - Latch op and sign flags sa=opa[31], sb=opb[31].
  - For MULT/DIV, latch |opa| and |opb|; otherwise latch the raw operands.
  - Clear count. div_zero <= (op is DIV/DIVU) and opb==0.
  - Go to CALC.
- CALC: one iteration per cycle, DATA_W cycles (edges E1..E32).
  - Multiply: shift-add into a 2*DATA_W accumulator.
  - Divide: restoring, one quotient bit per cycle.
  - At count==DATA_W-1, go to FIX.
- FIX, edge E33: commit HI/LO, pulse done=1 for the following cycle, go to IDLE.
  - Signed multiply: negate the 64-bit product if sa^sb.
  - Signed divide: negate the quotient if sa^sb; negate the remainder if sa. Arithmetic is modulo 2^32, so 0x80000000/-1 gives LO=0x80000000, HI=0.
  - HI = product[63:32] or remainder; LO = product[31:0] or quotient.
- Divide by zero: HI=opa (original, unsigned view), LO=all ones, for both DIV and DIVU. Latency is unchanged.
- Latency: start edge to visible HI/LO is 34 cycles. busy=1 from after E0 through E33.
- freeze (combinational) = busy & (start | mfhi_req | mflo_req | mthi_we | mtlo_we).
  - While busy, start and MT writes are ignored; the requester holds them under freeze.
  - In the done cycle busy=0, so reads see the new value.
- IDLE with MT write and start in the same cycle: the MT write commits at that edge and start is also accepted. The later result overwrites HI/LO.
- mthi_we and mtlo_we together are legal: both are written.
- hi and lo are always the registered architectural values. No partial results are ever exposed.

Decomposition:
- Package muldiv_pkg:
  - op encoding enum (MULT, MULTU, DIV, DIVU);
  - state enum (IDLE, CALC, FIX);
  - DATA_W default;
  - divide-by-zero LO constant (all ones).
- One sub-module, muldiv_iter_core:
  - holds the accumulator, divisor/remainder registers and the shift-add/subtract step;
  - inputs: load, step, is_div;
  - outputs: raw 64-bit product or {remainder, quotient}.
- The sequencer keeps the FSM, count, sign fixup, HI/LO and freeze.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> after 34 cycles HI=0xFFFFFFFE, LO=0x00000001; done high exactly one cycle; busy low in that cycle.
- MULT -3*7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 5/0 -> HI=0x00000005, LO=0xFFFFFFFF, div_zero=1. Next MULTU 2*3 -> div_zero=0, LO=6, HI=0.
- mflo_req held from cycle 5 after start -> freeze=1 every cycle until the done cycle, then 0 with lo showing the new result. A second start held while busy -> freeze=1, accepted at the done cycle, result 34 cycles later.
- IDLE: mthi_we with wdata=0x1234 plus mtlo_we with 0x5678 -> hi=0x1234, lo=0x5678 next cycle. The same MT write issued while busy -> freeze=1, no change until done.
- RESET low at CALC count 10 -> immediately hi=lo=0, busy=0, freeze=0. After release, DIVU 100/7 -> LO=14, HI=2 in 34 cycles.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned DefDataW = 32;

    // Sliced down to DATA_W by users; covers widths up to 64.
    localparam logic [63:0] DivZeroLo = '1;

    typedef enum logic [1:0] {
        OpMult  = 2'b00,
        OpMultu = 2'b01,
        OpDiv   = 2'b10,
        OpDivu  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix
    } state_e;

endpackage

// File: rtl/muldiv_iter_core.sv
// Unsigned 1-bit-per-cycle engine: shift-add multiply and restoring divide.
module muldiv_iter_core
    import muldiv_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                load,
    input  logic                step,
    input  logic                is_div,
    input  logic [DATA_W-1:0]   opa,
    input  logic [DATA_W-1:0]   opb,
    output logic [2*DATA_W-1:0] result
);

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0]   dvsr_q, dvsr_d;
    logic [DATA_W:0]     add_sum;
    logic [DATA_W:0]     sub_diff;

    always_comb begin
        add_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, dvsr_q};
        sub_diff = acc_q[2*DATA_W-1:DATA_W-1] - {1'b0, dvsr_q};
        acc_d    = acc_q;
        dvsr_d   = dvsr_q;
        if (load) begin
            acc_d  = is_div ? {{DATA_W{1'b0}}, opa} : {{DATA_W{1'b0}}, opb};
            dvsr_d = is_div ? opb : opa;
        end else if (step) begin
            if (is_div) begin
                if (!sub_diff[DATA_W]) begin
                    acc_d = {sub_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
                end else begin
                    acc_d = {acc_q[2*DATA_W-2:0], 1'b0};
                end
            end else if (acc_q[0]) begin
                acc_d = {add_sum, acc_q[DATA_W-1:1]};
            end else begin
                acc_d = {1'b0, acc_q[2*DATA_W-1:1]};
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            acc_q  <= '0;
            dvsr_q <= '0;
        end else begin
            acc_q  <= acc_d;
            dvsr_q <= dvsr_d;
        end
    end

    assign result = acc_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// HI/LO owner: sequences the iterative mul/div core, applies sign fixup, serves MF/MT and freeze.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int unsigned       DATA_W   = DefDataW,
    parameter logic [DATA_W-1:0] HILO_RST = '0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] opa,
    input  logic [DATA_W-1:0] opb,
    input  logic              mfhi_req,
    input  logic              mflo_req,
    input  logic              mthi_we,
    input  logic              mtlo_we,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              busy,
    output logic              done,
    output logic              freeze,
    output logic              div_zero
);

    localparam int unsigned       CntW    = $clog2(DATA_W);
    localparam logic [CntW-1:0]   LastCnt = CntW'(DATA_W - 1);

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    op_e                 op_q;
    logic                sa_q, sb_q;
    logic [DATA_W-1:0]   opa_q;
    logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic                done_q, div_zero_q;

    logic                load, step, core_is_div, accept;
    logic                in_signed;
    logic [DATA_W-1:0]   mag_a, mag_b;
    logic [2*DATA_W-1:0] raw, prod;
    logic [DATA_W-1:0]   quo, rem;

    // Signed ops feed magnitudes to the unsigned core; sign is restored in FIX.
    assign in_signed   = ~op[0];
    assign mag_a       = (in_signed && opa[DATA_W-1]) ? -opa : opa;
    assign mag_b       = (in_signed && opb[DATA_W-1]) ? -opb : opb;
    assign core_is_div = (state_q == StIdle) ? op[1] : op_q[1];
    assign accept      = (state_q == StIdle) && start;

    muldiv_iter_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .CLK    (CLK),
        .RESET  (RESET),
        .load   (load),
        .step   (step),
        .is_div (core_is_div),
        .opa    (mag_a),
        .opb    (mag_b),
        .result (raw)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                step  = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    state_d = StFix;
                end
            end
            StFix:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        prod = (!op_q[0] && (sa_q ^ sb_q)) ? -raw : raw;
        quo  = raw[DATA_W-1:0];
        rem  = raw[2*DATA_W-1:DATA_W];
        if (!op_q[0]) begin
            if (sa_q ^ sb_q) quo = -quo;
            if (sa_q)        rem = -rem;
        end
        hi_d = hi_q;
        lo_d = lo_q;
        if (state_q == StFix) begin
            if (!op_q[1]) begin
                hi_d = prod[2*DATA_W-1:DATA_W];
                lo_d = prod[DATA_W-1:0];
            end else if (div_zero_q) begin
                hi_d = opa_q;
                lo_d = DivZeroLo[DATA_W-1:0];
            end else begin
                hi_d = rem;
                lo_d = quo;
            end
        end else if (state_q == StIdle) begin
            if (mthi_we) hi_d = wdata;
            if (mtlo_we) lo_d = wdata;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            op_q       <= OpMult;
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
            opa_q      <= '0;
            hi_q       <= HILO_RST;
            lo_q       <= HILO_RST;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= (state_q == StFix);
            if (accept) begin
                op_q       <= op_e'(op);
                sa_q       <= opa[DATA_W-1];
                sb_q       <= opb[DATA_W-1];
                opa_q      <= opa;
                div_zero_q <= op[1] && (opb == '0);
            end
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = (state_q != StIdle);
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign freeze   = busy && (start || mfhi_req || mflo_req || mthi_we || mtlo_we);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: vector table, random ops vs. arithmetic model, corner sequences.
module tb_muldiv_sequencer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        start, mfhi_req, mflo_req, mthi_we, mtlo_we;
    logic [1:0]  op;
    logic [31:0] opa, opb, wdata;
    logic [31:0] hi, lo;
    logic        busy, done, freeze, div_zero;

    int checks = 0;
    int errors = 0;

    muldiv_sequencer dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .start    (start),
        .op       (op),
        .opa      (opa),
        .opb      (opb),
        .mfhi_req (mfhi_req),
        .mflo_req (mflo_req),
        .mthi_we  (mthi_we),
        .mtlo_we  (mtlo_we),
        .wdata    (wdata),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done),
        .freeze   (freeze),
        .div_zero (div_zero)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
        logic        edz;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // MIPS semantics in plain arithmetic: truncating signed divide, results modulo 2^32.
    task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el);
        longint          sa, sb, sp;
        longint unsigned up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'd0: begin sp = sa * sb; eh = sp[63:32]; el = sp[31:0]; end
            2'd1: begin up = {32'b0, a} * {32'b0, b}; eh = up[63:32]; el = up[31:0]; end
            2'd2: begin
                if (b == 0) begin eh = a; el = '1; end
                else begin sp = sa / sb; el = sp[31:0]; sp = sa % sb; eh = sp[31:0]; end
            end
            default: begin
                if (b == 0) begin eh = a; el = '1; end
                else begin el = a / b; eh = a % b; end
            end
        endcase
    endtask

    // Called at a negedge after the start edge (cycle 1); returns at the done cycle or on timeout.
    task automatic wait_done(output int cyc, output bit busy_ok);
        cyc = 1;
        busy_ok = 1'b1;
        while (!done && cyc < 60) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge CLK);
            cyc++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input logic edz);
        int cyc;
        bit busy_ok;
        op = o; opa = a; opb = b; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        wait_done(cyc, busy_ok);
        check({tag, " latency"}, cyc, 34);
        check({tag, " busy_in_flight"}, {31'b0, busy_ok}, 1);
        check({tag, " busy_at_done"}, {31'b0, busy}, 0);
        check({tag, " hi"}, hi, eh);
        check({tag, " lo"}, lo, el);
        check({tag, " div_zero"}, {31'b0, div_zero}, {31'b0, edz});
        @(negedge CLK);
        check({tag, " done_one_cycle"}, {31'b0, done}, 0);
    endtask

    initial begin
        int          cyc;
        bit          busy_ok, ok;
        logic [1:0]  ro;
        logic [31:0] ra, rb, eh, el;

        vecs[0] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1] = '{2'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[2] = '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3] = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[4] = '{2'd3, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1};
        vecs[5] = '{2'd1, 32'h00000002, 32'h00000003, 32'h00000000, 32'h00000006, 1'b0};
        vecs[6] = '{2'd2, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
        vecs[7] = '{2'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};

        RESET = 1'b0; start = 1'b0; op = '0; opa = '0; opb = '0; wdata = '0;
        mfhi_req = 1'b0; mflo_req = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0;
        #12;
        check("rst hi", hi, 0);
        check("rst lo", lo, 0);
        check("rst busy", {31'b0, busy}, 0);
        check("rst done", {31'b0, done}, 0);
        check("rst freeze", {31'b0, freeze}, 0);
        check("rst div_zero", {31'b0, div_zero}, 0);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].o, vecs[i].a, vecs[i].b,
                   vecs[i].eh, vecs[i].el, vecs[i].edz);
        end

        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
            model(ro, ra, rb, eh, el);
            run_op($sformatf("rand%0d", i), ro, ra, rb, eh, el, ro[1] && (rb == 0));
        end

        // mflo held from cycle 5: freeze until the done cycle, which shows the new LO.
        op = 2'd1; opa = 6; opb = 7; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        cyc = 1; ok = 1'b1;
        while (!done && cyc < 60) begin
            if (cyc == 5) mflo_req = 1'b1;
            #1;
            if (freeze !== (cyc >= 5)) ok = 1'b0;
            @(negedge CLK);
            cyc++;
        end
        #1;
        check("mflo freeze_window", {31'b0, ok}, 1);
        check("mflo latency", cyc, 34);
        check("mflo freeze_at_done", {31'b0, freeze}, 0);
        check("mflo lo_at_done", lo, 42);
        @(negedge CLK);
        mflo_req = 1'b0;

        // Second start held under freeze, accepted in the done cycle.
        op = 2'd3; opa = 100; opb = 7; start = 1'b1;
        @(negedge CLK);
        cyc = 1; ok = 1'b1;
        while (!done && cyc < 60) begin
            if (cyc == 1) start = 1'b0;
            if (cyc == 3) begin op = 2'd1; opa = 3; opb = 5; start = 1'b1; end
            #1;
            if (freeze !== (cyc >= 3)) ok = 1'b0;
            @(negedge CLK);
            cyc++;
        end
        #1;
        check("hold freeze_window", {31'b0, ok}, 1);
        check("hold first_hi", hi, 2);
        check("hold first_lo", lo, 14);
        check("hold freeze_at_done", {31'b0, freeze}, 0);
        @(negedge CLK);
        start = 1'b0;
        wait_done(cyc, busy_ok);
        check("hold second_latency", cyc, 34);
        check("hold second_hi", hi, 0);
        check("hold second_lo", lo, 15);
        @(negedge CLK);

        // MT writes in IDLE, separately and together.
        mthi_we = 1'b1; wdata = 32'h1234;
        @(negedge CLK);
        mthi_we = 1'b0; mtlo_we = 1'b1; wdata = 32'h5678;
        @(negedge CLK);
        mtlo_we = 1'b0;
        check("mt hi", hi, 32'h1234);
        check("mt lo", lo, 32'h5678);
        mthi_we = 1'b1; mtlo_we = 1'b1; wdata = 32'hABCD;
        @(negedge CLK);
        mthi_we = 1'b0; mtlo_we = 1'b0;
        check("mt_both hi", hi, 32'hABCD);
        check("mt_both lo", lo, 32'hABCD);

        // MT write issued while busy: frozen, no HI change until done, then commits.
        op = 2'd1; opa = 2; opb = 3; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        cyc = 1; ok = 1'b1;
        while (!done && cyc < 60) begin
            if (cyc == 2) begin mthi_we = 1'b1; wdata = 32'hDEAD; end
            #1;
            if (cyc >= 2 && (freeze !== 1'b1 || hi !== 32'hABCD)) ok = 1'b0;
            @(negedge CLK);
            cyc++;
        end
        #1;
        check("mt_busy frozen_unchanged", {31'b0, ok}, 1);
        check("mt_busy hi_at_done", hi, 0);
        check("mt_busy lo_at_done", lo, 6);
        check("mt_busy freeze_at_done", {31'b0, freeze}, 0);
        @(negedge CLK);
        mthi_we = 1'b0;
        check("mt_busy hi_after", hi, 32'hDEAD);

        // MT and start together in IDLE: MT lands now, result overwrites later.
        mthi_we = 1'b1; wdata = 32'h55; op = 2'd1; opa = 4; opb = 5; start = 1'b1;
        @(negedge CLK);
        mthi_we = 1'b0; start = 1'b0;
        check("mt_start hi_now", hi, 32'h55);
        wait_done(cyc, busy_ok);
        check("mt_start latency", cyc, 34);
        check("mt_start hi", hi, 0);
        check("mt_start lo", lo, 20);
        @(negedge CLK);
        mthi_we = 1'b1; wdata = 32'hBEEF;
        @(negedge CLK);
        mthi_we = 1'b0;

        // Asynchronous reset at CALC count 10 discards the operation.
        op = 2'd1; opa = 32'hFFFFFFFF; opb = 32'hFFFFFFFF; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        for (int i = 1; i < 11; i++) @(negedge CLK);
        mflo_req = 1'b1;
        #1;
        check("rst_mid freeze_before", {31'b0, freeze}, 1);
        RESET = 1'b0;
        #1;
        check("rst_mid hi", hi, 0);
        check("rst_mid lo", lo, 0);
        check("rst_mid busy", {31'b0, busy}, 0);
        check("rst_mid freeze", {31'b0, freeze}, 0);
        @(negedge CLK);
        RESET = 1'b1; mflo_req = 1'b0;
        @(negedge CLK);
        run_op("after_rst", 2'd3, 100, 7, 2, 14, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
